// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: SRAM-like req/addr_ok/data_ok on the fetch side, AXI4 single-beat reads on the bus side.
// state   | meaning
// AR_IDLE | no AR pending; fetch requests may be accepted
// AR_WAIT | AR presented on the bus, waiting for arready
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID            = 4'd0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rresp_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {AR_IDLE, AR_WAIT} ar_state_t;

  ar_state_t       state, state_next;
  logic [CW-1:0]   outstanding;
  logic [1:0]      size_q;
  logic            rbeat;

  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arsize  = {1'b0, size_q};
  assign arvalid = (state == AR_WAIT);

  assign rready            = resetn;
  assign rbeat             = rvalid & rready & (rid == ARID);
  assign inst_sram_data_ok = rbeat & rlast;
  assign inst_sram_rdata   = rdata;

  // addr_ok depends only on registered state, never on arready
  always_comb begin
    state_next        = state;
    inst_sram_addr_ok = 1'b0;
    case (state)
      AR_IDLE: begin
        inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr &
                            (outstanding < CW'(MAX_OUTSTANDING));
        if (inst_sram_addr_ok) state_next = AR_WAIT;
      end
      AR_WAIT: begin
        if (arready) state_next = AR_IDLE;
      end
      default: state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= AR_IDLE;
      araddr <= 32'd0;
      size_q <= 2'd0;
    end else begin
      state <= state_next;
      if (inst_sram_addr_ok) begin
        araddr <= inst_sram_addr;
        size_q <= inst_sram_size;
      end
    end
  end

  // A data_ok with nothing outstanding is a fetch-side protocol error; hold at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      outstanding <= '0;
    end else if (inst_sram_addr_ok && !inst_sram_data_ok) begin
      outstanding <= outstanding + 1'b1;
    end else if (!inst_sram_addr_ok && inst_sram_data_ok && outstanding != '0) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                      rresp_err <= 1'b0;
    else if (rbeat && rresp != 2'b00) rresp_err <= 1'b1;
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized and directed bench for inst_axi_rd_bridge against a transaction-level model.
module tb_inst_axi_rd_bridge;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, rresp_err;

  int vectors = 0;
  int miscompares = 0;

  // transaction-level model state
  bit          m_pend;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  int          m_cnt;
  bit          m_err;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rresp_err(rresp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_addr = '0; m_size = '0; m_cnt = 0; m_err = 0;
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, advance model at posedge
  task automatic step(input logic rn, input logic rq, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic ardy, input logic rv,
                      input logic [3:0] id, input logic [31:0] rd, input logic [1:0] rr,
                      input logic rl);
    bit e_aok, e_dok, beat;
    @(negedge clk);
    resetn = rn; inst_sram_req = rq; inst_sram_wr = w; inst_sram_addr = a;
    inst_sram_size = sz; arready = ardy; rvalid = rv; rid = id; rdata = rd;
    rresp = rr; rlast = rl;
    #1;
    e_aok = !m_pend && rq && !w && (m_cnt < MAXO);
    beat  = rn && rv && (id == 4'd0);
    e_dok = beat && rl;
    chk("addr_ok",   32'(inst_sram_addr_ok), 32'(e_aok));
    chk("arvalid",   32'(arvalid),           32'(m_pend));
    chk("araddr",    araddr,                 m_addr);
    chk("arsize",    32'(arsize),            {29'd0, 1'b0, m_size});
    chk("data_ok",   32'(inst_sram_data_ok), 32'(e_dok));
    chk("rready",    32'(rready),            32'(rn));
    chk("rresp_err", 32'(rresp_err),         32'(m_err));
    if (e_dok) chk("rdata", inst_sram_rdata, rd);
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (m_pend && ardy) m_pend = 0;
      if (e_aok) begin m_pend = 1; m_addr = a; m_size = sz; end
      m_cnt = m_cnt + int'(e_aok) - int'(e_dok);
      if (m_cnt < 0) m_cnt = 0;
      if (beat && rr != 2'b00) m_err = 1;
    end
  endtask

  // idle helper: no request, optional R beat
  task automatic idle(input logic ardy, input logic rv, input logic [3:0] id,
                      input logic [31:0] rd, input logic [1:0] rr);
    step(1, 0, 0, 32'h0, 2'd0, ardy, rv, id, rd, rr, 1);
  endtask

  initial begin
    resetn = 0; inst_sram_req = 0; inst_sram_wr = 0; inst_sram_addr = '0;
    inst_sram_size = '0; arready = 0; rvalid = 0; rid = '0; rdata = '0;
    rresp = '0; rlast = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("arlen",   32'(arlen),   32'h0);
    chk("arburst", 32'(arburst), 32'h1);
    chk("arid",    32'(arid),    32'h0);
    chk("arcache", 32'({arlock, arcache, arprot}), 32'h0);

    // single fetch: accept cycle 0, AR handshake cycle 1, R beat cycle 3
    step(1, 1, 0, 32'h1c000000, 2'd2, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(0, 1, 0, 32'h02800c0c, 0);
    // outstanding back at 0: two more accepts allowed before blocking
    step(1, 1, 0, 32'h1c000004, 2'd2, 0, 0, 0, 0, 0, 0);
    // AR backpressure for 5 cycles with req held high
    repeat (5) step(1, 1, 0, 32'hdeadbeef, 2'd1, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0, 0);
    step(1, 1, 0, 32'h1c000008, 2'd2, 1, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0, 0);
    // limit reached: req blocked
    repeat (3) step(1, 1, 0, 32'h1c00000c, 2'd2, 1, 0, 0, 0, 0, 0);
    // rid mismatch: no data_ok, still blocked
    step(1, 1, 0, 32'h1c00000c, 2'd2, 1, 1, 4'd3, 32'h11111111, 0, 1);
    // one return, then accept together with a return
    idle(1, 1, 0, 32'h22222222, 0);
    step(1, 1, 0, 32'h1c000010, 2'd2, 1, 1, 0, 32'h33333333, 0, 1);
    idle(1, 0, 0, 0, 0);
    // error response: data_ok still asserted, rresp_err sticky
    idle(1, 1, 0, 32'h44444444, 2'b10);
    idle(1, 0, 0, 0, 0);
    idle(1, 1, 0, 32'h55555555, 2'b00);
    // write requests never accepted
    repeat (3) step(1, 1, 1, 32'h1c000100, 2'd2, 1, 0, 0, 0, 0, 0);
    // reset while arvalid high, then fresh request
    step(1, 1, 0, 32'h1c000200, 2'd2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h1c000300, 2'd0, 1, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) == 0,
           $urandom,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 4,
           ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
           $urandom,
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           $urandom_range(0, 9) < 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
